// File: rtl/cpu19_pkg.sv
// Shared definitions for the cpu19 pipeline hazard logic: opcodes,
// multi-cycle latencies, forwarding-select encodings, stall FSM states.
package cpu19_pkg;

    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;

    // Total EX occupancy of each multi-cycle operation, in cycles.
    localparam logic [4:0] LAT_MUL = 5'd4;
    localparam logic [4:0] LAT_DIV = 5'd20;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mc_state_e;

    // True when the opcode occupies EX for more than one cycle.
    function automatic logic is_mc_op(input logic [4:0] op);
        logic r;
        case (op)
            OP_MUL:  r = 1'b1;
            OP_DIV:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Counter preload: the RUN cycle and the DONE cycle are not counted,
    // and BUSY lasts cnt+1 cycles, so preload is latency-3.
    function automatic logic [4:0] mc_cnt_load(input logic [4:0] op);
        logic [4:0] r;
        case (op)
            OP_MUL:  r = LAT_MUL - 5'd3;
            OP_DIV:  r = LAT_DIV - 5'd3;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Operand source select; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [2:0] mem_dst,
        input logic       wb_we,
        input logic [2:0] wb_dst,
        input logic [2:0] src
    );
        logic [1:0] r;
        if (mem_we && (mem_dst == src)) begin
            r = FWD_MEM;
        end else if (wb_we && (wb_dst == src)) begin
            r = FWD_WB;
        end else begin
            r = FWD_REG;
        end
        return r;
    endfunction

endpackage

// File: rtl/mc_stall_fsm.sv
// Multi-cycle EX stall sequencer: RUN detects a MUL/DIV, BUSY counts down
// the remaining occupancy, DONE releases the pipeline for one cycle.
module mc_stall_fsm
    import cpu19_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ex_opcode_i,
    output logic       mc_stall_o,
    output logic       busy_o,
    output logic       done_o
);

    mc_state_e  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and stall/status decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (is_mc_op(ex_opcode_i)) begin
                    mc_stall_o = 1'b1;
                    cnt_d      = mc_cnt_load(ex_opcode_i);
                    state_d    = ST_BUSY;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_BUSY: begin
                mc_stall_o = 1'b1;
                busy_o     = 1'b1;
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, taken-branch
// flush and multi-cycle EX stall control.
module hazard_unit
    import cpu19_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ID_rs,
    input  logic [2:0] ID_rt,
    input  logic [4:0] EX_opcode,
    input  logic       EX_memread,
    input  logic       EX_regdist,
    input  logic [2:0] EX_rs,
    input  logic [2:0] EX_rt,
    input  logic [2:0] EX_rd,
    input  logic       MEM_regwrite,
    input  logic [2:0] MEM_dst,
    input  logic       WB_regwrite,
    input  logic [2:0] WB_dst,
    input  logic       branch_taken,
    output logic       pc_hold,
    output logic       ifid_hold,
    output logic       ifid_flush,
    output logic       idex_hold,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       ex_busy,
    output logic       ex_done
);

    logic       mc_stall_s;
    logic       busy_s;
    logic       done_s;
    logic [2:0] ex_dst_s;
    logic       load_use_s;
    logic       branch_s;

    mc_stall_fsm u_mc_stall_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_opcode_i (EX_opcode),
        .mc_stall_o  (mc_stall_s),
        .busy_o      (busy_s),
        .done_o      (done_s)
    );

    // Forwarding selects; these stay live even while reset is asserted.
    always_comb begin
        fwd_a = fwd_sel(MEM_regwrite, MEM_dst, WB_regwrite, WB_dst, EX_rs);
        fwd_b = fwd_sel(MEM_regwrite, MEM_dst, WB_regwrite, WB_dst, EX_rt);
    end

    // Load-use and branch detection; both are ignored while EX is busy.
    always_comb begin
        ex_dst_s   = EX_regdist ? EX_rd : EX_rt;
        load_use_s = EX_memread && ((ex_dst_s == ID_rs) || (ex_dst_s == ID_rt))
                     && !busy_s;
        branch_s   = branch_taken && !busy_s;
    end

    // Front-end and pipeline-register control; a taken branch cancels the
    // load-use hold, and everything is forced low while reset is asserted.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ex_busy      = 1'b0;
        ex_done      = 1'b0;
        if (rst_n) begin
            pc_hold      = mc_stall_s | (load_use_s & ~branch_s);
            ifid_hold    = mc_stall_s | (load_use_s & ~branch_s);
            ifid_flush   = branch_s;
            idex_hold    = mc_stall_s;
            idex_bubble  = load_use_s | branch_s;
            exmem_bubble = mc_stall_s;
            ex_busy      = busy_s;
            ex_done      = done_s;
        end else begin
            pc_hold      = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver computes expected outputs
// from an occupancy model and queues them; the monitor samples and compares.
module tb_hazard_unit;
    import cpu19_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_rd, MEM_dst, WB_dst;
    logic [4:0] EX_opcode;
    logic       EX_memread, EX_regdist, MEM_regwrite, WB_regwrite, branch_taken;
    logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic       ex_busy, ex_done;

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   stim_done = 1'b0;

    // Model: remaining busy cycles and a pending DONE cycle.
    int   busy_left = 0;
    bit   done_pend = 1'b0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .EX_opcode(EX_opcode), .EX_memread(EX_memread), .EX_regdist(EX_regdist),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
        .MEM_regwrite(MEM_regwrite), .MEM_dst(MEM_dst),
        .WB_regwrite(WB_regwrite), .WB_dst(WB_dst),
        .branch_taken(branch_taken),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_busy(ex_busy), .ex_done(ex_done)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [2:0] src);
        if (MEM_regwrite && MEM_dst == src) return 2'b01;
        if (WB_regwrite && WB_dst == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        ID_rs = 3'd0; ID_rt = 3'd0; EX_rs = 3'd0; EX_rt = 3'd0; EX_rd = 3'd0;
        MEM_dst = 3'd0; WB_dst = 3'd0; EX_opcode = 5'd0;
        EX_memread = 1'b0; EX_regdist = 1'b0; MEM_regwrite = 1'b0;
        WB_regwrite = 1'b0; branch_taken = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: queue the
    // expectation for this cycle, advance the model, wait one cycle.
    task automatic step(input string tag);
        exp_t e;
        bit busy, done, run, mc, lu, br, stall, lu_hold;
        logic [2:0] dst;
        int lat;
        if (!rst_n) begin
            busy_left = 0;
            done_pend = 1'b0;
        end
        busy  = rst_n && (busy_left > 0);
        done  = rst_n && !busy && done_pend;
        run   = rst_n && !busy && !done;
        mc    = run && (EX_opcode == OP_MUL || EX_opcode == OP_DIV);
        dst   = EX_regdist ? EX_rd : EX_rt;
        lu    = rst_n && !busy && EX_memread && (dst == ID_rs || dst == ID_rt);
        br    = rst_n && !busy && branch_taken;
        stall = mc || busy;
        lu_hold = lu && !br;
        e.v = {stall | lu_hold, stall | lu_hold, br, stall, lu | br, stall,
               ref_fwd(EX_rs), ref_fwd(EX_rt), busy, done};
        e.tag = tag;
        q.push_back(e);
        if (rst_n) begin
            if (busy) begin
                busy_left--;
                if (busy_left == 0) done_pend = 1'b1;
            end else if (done) begin
                done_pend = 1'b0;
            end else if (mc) begin
                lat = (EX_opcode == OP_MUL) ? 4 : 20;
                busy_left = lat - 2;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: sample settled outputs mid-low-phase and compare.
    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                act = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
                       exmem_bubble, fwd_a, fwd_b, ex_busy, ex_done};
                checks++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b (pc,ifh,iff,idh,idb,emb,fa,fb,busy,done)",
                             e.tag, act, e.v);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int r;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        step("reset_idle");
        MEM_regwrite = 1'b1; MEM_dst = 3'd2; EX_rs = 3'd2; EX_opcode = OP_MUL;
        step("reset_fwd_live");
        rst_n = 1'b1;
        clear_inputs();
        step("idle");

        // Forwarding priority, then MEM/WB only, then r0 on operand b.
        MEM_regwrite = 1'b1; MEM_dst = 3'b101; WB_regwrite = 1'b1; WB_dst = 3'b101;
        EX_rs = 3'b101;
        step("fwd_mem_prio");
        MEM_regwrite = 1'b0;
        step("fwd_wb");
        MEM_regwrite = 1'b1; MEM_dst = 3'd0; EX_rt = 3'd0;
        step("fwd_b_r0");
        clear_inputs();

        // Load-use on rt.
        EX_memread = 1'b1; EX_regdist = 1'b0; EX_rt = 3'b110; ID_rt = 3'b110;
        step("load_use");
        clear_inputs();
        step("load_use_after");

        // MUL held in EX until DONE, then the pipeline advances.
        EX_opcode = OP_MUL;
        for (int i = 0; i < 4; i++) step("mul");
        EX_opcode = 5'd0;
        step("mul_after");

        // DIV aborted by reset after 5 stall cycles.
        EX_opcode = OP_DIV;
        for (int i = 0; i < 5; i++) step("div_pre_reset");
        rst_n = 1'b0;
        step("div_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("div_full");
        EX_opcode = 5'd0;
        step("div_after");

        // Branch overrides load-use; branch ignored while busy.
        EX_memread = 1'b1; EX_rt = 3'd3; ID_rs = 3'd3; branch_taken = 1'b1;
        step("branch_over_lu");
        clear_inputs();
        EX_opcode = OP_MUL;
        step("mul_start");
        branch_taken = 1'b1;
        EX_memread = 1'b1; EX_rt = 3'd4; ID_rt = 3'd4;
        step("busy_branch");
        step("busy_branch2");
        step("done_branch");
        clear_inputs();

        // Back-to-back MULs: the held opcode restarts after DONE.
        EX_opcode = OP_MUL;
        for (int i = 0; i < 8; i++) step("mul_b2b");
        EX_opcode = 5'd0;
        step("b2b_after");

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      EX_opcode = OP_MUL;
            else if (r == 1) EX_opcode = OP_DIV;
            else begin
                EX_opcode = 5'($urandom_range(0, 31));
                if (EX_opcode == OP_MUL || EX_opcode == OP_DIV) EX_opcode = 5'd0;
            end
            ID_rs = 3'($urandom_range(0, 7)); ID_rt = 3'($urandom_range(0, 7));
            EX_rs = 3'($urandom_range(0, 7)); EX_rt = 3'($urandom_range(0, 7));
            EX_rd = 3'($urandom_range(0, 7));
            MEM_dst = 3'($urandom_range(0, 7)); WB_dst = 3'($urandom_range(0, 7));
            EX_memread   = 1'($urandom_range(0, 1));
            EX_regdist   = 1'($urandom_range(0, 1));
            MEM_regwrite = 1'($urandom_range(0, 1));
            WB_regwrite  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 4) == 0);
            rst_n        = ($urandom_range(0, 49) != 0);
            step("random");
        end
        stim_done = 1'b1;
    end

    // Completion with a bounded drain of the scoreboard.
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!stim_done || q.size() != 0) begin
            fails++;
            $display("FAIL drain: done=%0d pending=%0d required done=1 pending=0",
                     stim_done, q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
